apb_rr_master_arb: RTL and testbench
====================================

Name: apb_rr_master_arb

Overview:
- Round-robin arbiter and APB sequencer that shares one APB master port between NUM_REQ internal requesters (DMA, CPU shim, debug).
- Latches the winning request and decodes its address to a one-hot slave select.
- Runs the SETUP/ACCESS phases toward the slaves.
- Returns read data and error to the winner with a single-cycle done pulse.
- Sits between the requesters and the apb_slave instances, replacing the bridge's externally driven psel.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- NUM_SLV, 2, number of APB slaves (1..4).
- SEL_LSB, 12, lowest paddr bit of the 2-bit slave-index field.
- TIMEOUT_CYCLES, 16, maximum ACCESS wait cycles (only with the optional feature).

Ports:
- pclk  in  1  APB clock; all logic on the rising edge.
- preset  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester request level; held until the matching done.
- req_addr  in  NUM_REQ x `D_WIDTH  per-requester address.
- req_write  in  NUM_REQ  1 = write.
- req_wdata  in  NUM_REQ x `D_WIDTH  write data.
- req_strb  in  NUM_REQ x 4  byte strobes.
- req_prot  in  NUM_REQ x 3  protection attributes.
- done  out  NUM_REQ  one-hot, one-cycle completion pulse.
- rsp_rdata  out  `D_WIDTH  read data; valid only in the done cycle.
- rsp_slverr  out  1  error; valid only in the done cycle.
- paddr  out  `D_WIDTH  APB address.
- pprot  out  3  APB protection.
- psel  out  NUM_SLV  one-hot APB slave select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- pwdata  out  `D_WIDTH  APB write data.
- pstrb  out  4  APB write strobes; 0 on reads.
- pready  in  1  muxed slave ready.
- prdata  in  `D_WIDTH  muxed slave read data.
- pslverr  in  1  muxed slave error.

Behaviour:
- Reset values: every output 0; FSM in IDLE; round-robin pointer = 0, meaning requester 0 has highest priority.
- FSM states: IDLE, SETUP, ACCESS, DECERR.
- IDLE
  - If any req is set, pick the first set index scanning from the pointer upward with wrap-around.
  - Register that requester's addr/write/wdata/strb/prot into the APB outputs.
  - Decode idx = paddr[SEL_LSB+1:SEL_LSB].
  - If idx < NUM_SLV: set psel[idx]=1 and go to SETUP.
  - Otherwise: no psel and go to DECERR.
- SETUP: penable=0 for exactly one cycle, then go to ACCESS with penable=1.
- ACCESS
  - Wait states: while pready=0, hold all APB outputs stable.
  - On pready=1:
    - Capture prdata (reads only; 0 on writes) into rsp_rdata.
    - Capture pslverr into rsp_slverr.
    - Pulse done[winner].
    - Drop psel and penable.
    - Advance the pointer to winner+1 mod NUM_REQ.
    - Return to IDLE.
- DECERR: one cycle, then done[winner]=1, rsp_slverr=1, rsp_rdata=0, pointer advances, IDLE.
- Latency, zero-wait slave: req seen in IDLE at cycle 0 → SETUP visible at 1 → ACCESS at 2 → done at 3.
- Minimum spacing:
  - Back-to-back transfers are separated by one IDLE cycle.
  - A requester must drop req in the cycle after done, or it is treated as a new request.
  - The rotated pointer still makes it lowest priority.
- Request timing:
  - Requests arriving while the FSM is not in IDLE are not sampled until IDLE.
  - A req deasserted mid-transfer does not abort the transfer; done still fires.
- Simultaneous requests are resolved only by the pointer, with no fixed priority.
  - With all NUM_REQ=3 requesting continuously, grant order is 0,1,2,0,…
- rsp_rdata and rsp_slverr hold their last value between done pulses.
- preset asserted mid-transfer: all outputs drop to 0 immediately (asynchronously), no done is issued, and the pointer returns to 0.

Optional Feature:
- Macro: APB_ARB_TIMEOUT_EN.
- When defined:
  - A $clog2(TIMEOUT_CYCLES+1)-bit counter clears on entering ACCESS and increments each ACCESS cycle with pready=0.
  - When it reaches TIMEOUT_CYCLES, the transfer ends as if pready=1 with pslverr forced to 1 and rdata 0: done pulses, the APB outputs drop, and the FSM returns to IDLE.
- When undefined: no counter exists and ACCESS waits indefinitely.

Decomposition:
- Package apb_arb_pkg:
  - FSM state enum (IDLE, SETUP, ACCESS, DECERR).
  - SEL_W = 2.
  - Struct apb_req_t {addr, write, wdata, strb, prot}.
- `D_WIDTH continues to come from defines.sv.
- Sub-module rr_arbiter (NUM_REQ req in; one-hot grant plus index out; advance strobe updates the pointer), combinational grant with registered pointer.

Test Plan:
- Single write, req[1]=1, addr 0x0000_0010, wdata 0xDEAD_BEEF, zero-wait slave 0 → psel=01 with penable=0 at cycle 1, penable=1 at cycle 2, done=010 at cycle 3, rsp_slverr=0.
- Read with 3 wait states, req[0], addr 0x0000_1004 → psel=10 held through 4 ACCESS cycles; done at cycle 6 with rsp_rdata equal to the slave word.
- All three requesters held high for 6 transfers → grant order 0,1,2,0,1,2; no requester granted twice in a row.
- Decode error, NUM_SLV=2, addr 0x0000_3000 (idx 3) → psel stays 0 and penable stays 0; done at cycle 2 with rsp_slverr=1 and rsp_rdata=0.
- preset pulsed during ACCESS with wait states → psel, penable and done are 0 the same cycle; after release, req[2] is granted only when req[0] and req[1] are low.
- APB_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=16 and pready stuck at 0 → done after 16 ACCESS cycles with rsp_slverr=1, then IDLE.

Source files
------------

// File: rtl/apb_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : apb_arb_pkg
//  Description : FSM encoding, slave-index width and request record for the
//                round-robin APB master arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`ifndef D_WIDTH
`define D_WIDTH 32
`endif

package apb_arb_pkg;

    // Width of the paddr field that selects the target slave
    localparam int SEL_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DECERR = 2'd3
    } arb_state_t;

    // One requester's transfer attributes as presented on the APB port
    typedef struct packed {
        logic [`D_WIDTH-1:0] addr;
        logic                write;
        logic [`D_WIDTH-1:0] wdata;
        logic [3:0]          strb;
        logic [2:0]          prot;
    } apb_req_t;

endpackage
`default_nettype wire

// File: rtl/defines.sv
`default_nettype none
// ============================================================================
//  File        : defines.sv
//  Description : Global bus-width definitions shared across the APB slice.
//  Revision    : 1.0 - initial release
// ============================================================================
`ifndef D_WIDTH
`define D_WIDTH 32
`endif
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin grant over NUM_REQ request lines
//                with a registered priority pointer. An advance strobe moves
//                the pointer to one past the supplied winner.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic                       i_advance,
    input  logic [$clog2(NUM_REQ)-1:0] i_winner,
    output logic [NUM_REQ-1:0]         o_grant,
    output logic [$clog2(NUM_REQ)-1:0] o_grant_idx
);

    localparam int c_idx_w = $clog2(NUM_REQ);

    logic [c_idx_w-1:0] r_ptr;
    logic [NUM_REQ-1:0] w_upper;
    logic [NUM_REQ-1:0] w_pool;

    // Prefer requests at or above the pointer; wrap to the full set otherwise
    always_comb begin
        w_upper = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_upper[i] = i_req[i] && (i >= int'(r_ptr));
        end
        w_pool      = (|w_upper) ? w_upper : i_req;
        o_grant     = '0;
        o_grant_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_pool[i]) begin
                o_grant     = '0;
                o_grant[i]  = 1'b1;
                o_grant_idx = c_idx_w'(i);
            end
        end
    end

    // Pointer moves to winner+1 (mod NUM_REQ) when a transfer completes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_advance) begin
            r_ptr <= (int'(i_winner) == NUM_REQ - 1) ? '0 : i_winner + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/apb_rr_master_arb.sv
`default_nettype none
// ============================================================================
//  Module      : apb_rr_master_arb
//  Description : Shares one APB master port between NUM_REQ requesters using
//                round-robin arbitration; decodes the slave select, sequences
//                SETUP/ACCESS and returns rdata/slverr with a done pulse.
//                Optional ACCESS timeout enabled by macro APB_ARB_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`ifndef D_WIDTH
`define D_WIDTH 32
`endif

module apb_rr_master_arb
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int NUM_SLV        = 2,
    parameter int SEL_LSB        = 12
`ifdef APB_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input  logic                              pclk,
    input  logic                              preset,
    input  logic [NUM_REQ-1:0]                req,
    input  logic [NUM_REQ-1:0][`D_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ-1:0]                req_write,
    input  logic [NUM_REQ-1:0][`D_WIDTH-1:0]  req_wdata,
    input  logic [NUM_REQ-1:0][3:0]           req_strb,
    input  logic [NUM_REQ-1:0][2:0]           req_prot,
    output logic [NUM_REQ-1:0]                done,
    output logic [`D_WIDTH-1:0]               rsp_rdata,
    output logic                              rsp_slverr,
    output logic [`D_WIDTH-1:0]               paddr,
    output logic [2:0]                        pprot,
    output logic [NUM_SLV-1:0]                psel,
    output logic                              penable,
    output logic                              pwrite,
    output logic [`D_WIDTH-1:0]               pwdata,
    output logic [3:0]                        pstrb,
    input  logic                              pready,
    input  logic [`D_WIDTH-1:0]               prdata,
    input  logic                              pslverr
);

    localparam int c_idx_w = $clog2(NUM_REQ);

    arb_state_t           r_state,  w_state_nxt;
    apb_req_t             r_apb,    w_apb_nxt;
    logic [NUM_SLV-1:0]   r_psel,   w_psel_nxt;
    logic                 r_penable, w_penable_nxt;
    logic [NUM_REQ-1:0]   r_done,   w_done_nxt;
    logic [`D_WIDTH-1:0]  r_rdata,  w_rdata_nxt;
    logic                 r_slverr, w_slverr_nxt;
    logic [c_idx_w-1:0]   r_winner, w_winner_nxt;

    logic [NUM_REQ-1:0]   w_grant;
    logic [c_idx_w-1:0]   w_grant_idx;
    logic                 w_advance;
    apb_req_t             w_sel;
    logic [SEL_W-1:0]     w_slv_idx;
    logic [NUM_SLV-1:0]   w_dec;
    logic [NUM_REQ-1:0]   w_win_oh;
    logic                 w_timeout;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .clk         (pclk),
        .rst         (preset),
        .i_req       (req),
        .i_advance   (w_advance),
        .i_winner    (r_winner),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );

    // Gather the granted requester's attributes and decode its slave select
    always_comb begin
        w_sel.addr  = req_addr[w_grant_idx];
        w_sel.write = req_write[w_grant_idx];
        w_sel.wdata = req_wdata[w_grant_idx];
        w_sel.strb  = req_write[w_grant_idx] ? req_strb[w_grant_idx] : 4'h0;
        w_sel.prot  = req_prot[w_grant_idx];
        w_slv_idx   = w_sel.addr[SEL_LSB +: SEL_W];
        w_dec       = '0;
        for (int s = 0; s < NUM_SLV; s++) begin
            w_dec[s] = (int'(w_slv_idx) == s);
        end
        w_win_oh = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_win_oh[i] = (int'(r_winner) == i);
        end
    end

`ifdef APB_ARB_TIMEOUT_EN
    localparam int                 c_tmo_w    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYCLES - 1);

    logic [c_tmo_w-1:0] r_tmo_cnt;

    // Count ACCESS wait cycles; cleared on the way into ACCESS
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_tmo_cnt <= '0;
        end else if (r_state == ST_SETUP) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == ST_ACCESS) && !pready) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    // Fires on the wait cycle that brings the count to TIMEOUT_CYCLES
    assign w_timeout = (r_state == ST_ACCESS) && !pready && (r_tmo_cnt == c_tmo_last);
`else
    assign w_timeout = 1'b0;
`endif

    // Next-state and next-output logic for the transfer sequencer
    always_comb begin
        w_state_nxt   = r_state;
        w_apb_nxt     = r_apb;
        w_psel_nxt    = r_psel;
        w_penable_nxt = r_penable;
        w_done_nxt    = '0;
        w_rdata_nxt   = r_rdata;
        w_slverr_nxt  = r_slverr;
        w_winner_nxt  = r_winner;
        w_advance     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|w_grant) begin
                    w_winner_nxt  = w_grant_idx;
                    w_apb_nxt     = w_sel;
                    w_psel_nxt    = w_dec;
                    w_penable_nxt = 1'b0;
                    w_state_nxt   = (|w_dec) ? ST_SETUP : ST_DECERR;
                end
            end
            ST_SETUP: begin
                w_penable_nxt = 1'b1;
                w_state_nxt   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (pready || w_timeout) begin
                    w_rdata_nxt   = (!r_apb.write && !w_timeout) ? prdata : '0;
                    w_slverr_nxt  = pslverr || w_timeout;
                    w_done_nxt    = w_win_oh;
                    w_psel_nxt    = '0;
                    w_penable_nxt = 1'b0;
                    w_advance     = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end
            end
            ST_DECERR: begin
                w_rdata_nxt  = '0;
                w_slverr_nxt = 1'b1;
                w_done_nxt   = w_win_oh;
                w_advance    = 1'b1;
                w_state_nxt  = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears every output immediately
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state   <= ST_IDLE;
            r_apb     <= '0;
            r_psel    <= '0;
            r_penable <= 1'b0;
            r_done    <= '0;
            r_rdata   <= '0;
            r_slverr  <= 1'b0;
            r_winner  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_apb     <= w_apb_nxt;
            r_psel    <= w_psel_nxt;
            r_penable <= w_penable_nxt;
            r_done    <= w_done_nxt;
            r_rdata   <= w_rdata_nxt;
            r_slverr  <= w_slverr_nxt;
            r_winner  <= w_winner_nxt;
        end
    end

    assign paddr      = r_apb.addr;
    assign pwrite     = r_apb.write;
    assign pwdata     = r_apb.wdata;
    assign pstrb      = r_apb.strb;
    assign pprot      = r_apb.prot;
    assign psel       = r_psel;
    assign penable    = r_penable;
    assign done       = r_done;
    assign rsp_rdata  = r_rdata;
    assign rsp_slverr = r_slverr;

endmodule
`default_nettype wire

// File: tb/tb_apb_rr_master_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_rr_master_arb
//  Description : Directed self-checking bench for apb_rr_master_arb.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_rr_master_arb;

    logic             pclk;
    logic             preset;
    logic [2:0]       req;
    logic [2:0][31:0] req_addr;
    logic [2:0]       req_write;
    logic [2:0][31:0] req_wdata;
    logic [2:0][3:0]  req_strb;
    logic [2:0][2:0]  req_prot;
    logic [2:0]       done;
    logic [31:0]      rsp_rdata;
    logic             rsp_slverr;
    logic [31:0]      paddr;
    logic [2:0]       pprot;
    logic [1:0]       psel;
    logic             penable;
    logic             pwrite;
    logic [31:0]      pwdata;
    logic [3:0]       pstrb;
    logic             pready;
    logic [31:0]      prdata;
    logic             pslverr;

    int total;
    int bad;

    apb_rr_master_arb dut (
        .pclk       (pclk),
        .preset     (preset),
        .req        (req),
        .req_addr   (req_addr),
        .req_write  (req_write),
        .req_wdata  (req_wdata),
        .req_strb   (req_strb),
        .req_prot   (req_prot),
        .done       (done),
        .rsp_rdata  (rsp_rdata),
        .rsp_slverr (rsp_slverr),
        .paddr      (paddr),
        .pprot      (pprot),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .pwdata     (pwdata),
        .pstrb      (pstrb),
        .pready     (pready),
        .prdata     (prdata),
        .pslverr    (pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // One clock: rising edge, then settle to the falling edge for sampling
    task automatic tick;
        @(posedge pclk);
        @(negedge pclk);
    endtask

    task automatic test_reset;
        preset = 1'b1;
        @(negedge pclk);
        @(negedge pclk);
        total++; if (psel !== 2'b00)      begin bad++; $display("FAIL rst_psel: got %b want 00", psel); end
        total++; if (penable !== 1'b0)    begin bad++; $display("FAIL rst_penable: got %b want 0", penable); end
        total++; if (done !== 3'b000)     begin bad++; $display("FAIL rst_done: got %b want 000", done); end
        total++; if (paddr !== 32'h0)     begin bad++; $display("FAIL rst_paddr: got %h want 0", paddr); end
        total++; if (pwrite !== 1'b0)     begin bad++; $display("FAIL rst_pwrite: got %b want 0", pwrite); end
        total++; if (pwdata !== 32'h0)    begin bad++; $display("FAIL rst_pwdata: got %h want 0", pwdata); end
        total++; if (pstrb !== 4'h0)      begin bad++; $display("FAIL rst_pstrb: got %h want 0", pstrb); end
        total++; if (pprot !== 3'h0)      begin bad++; $display("FAIL rst_pprot: got %h want 0", pprot); end
        total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata: got %h want 0", rsp_rdata); end
        total++; if (rsp_slverr !== 1'b0) begin bad++; $display("FAIL rst_slverr: got %b want 0", rsp_slverr); end
        preset = 1'b0;
        tick();
        total++; if (psel !== 2'b00)      begin bad++; $display("FAIL idle_psel: got %b want 00", psel); end
    endtask

    task automatic test_single_write;
        req_addr[1]  = 32'h0000_0010;
        req_write[1] = 1'b1;
        req_wdata[1] = 32'hDEAD_BEEF;
        req_strb[1]  = 4'hF;
        req_prot[1]  = 3'b010;
        pready = 1'b1; pslverr = 1'b0;
        req = 3'b010;
        tick();
        total++; if (psel !== 2'b01)          begin bad++; $display("FAIL wr_setup_psel: got %b want 01", psel); end
        total++; if (penable !== 1'b0)        begin bad++; $display("FAIL wr_setup_penable: got %b want 0", penable); end
        total++; if (paddr !== 32'h10)        begin bad++; $display("FAIL wr_paddr: got %h want 10", paddr); end
        total++; if (pwdata !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_pwdata: got %h want deadbeef", pwdata); end
        total++; if (pwrite !== 1'b1)         begin bad++; $display("FAIL wr_pwrite: got %b want 1", pwrite); end
        total++; if (pstrb !== 4'hF)          begin bad++; $display("FAIL wr_pstrb: got %h want f", pstrb); end
        total++; if (pprot !== 3'b010)        begin bad++; $display("FAIL wr_pprot: got %b want 010", pprot); end
        tick();
        total++; if (penable !== 1'b1)        begin bad++; $display("FAIL wr_access_penable: got %b want 1", penable); end
        total++; if (done !== 3'b000)         begin bad++; $display("FAIL wr_early_done: got %b want 000", done); end
        tick();
        total++; if (done !== 3'b010)         begin bad++; $display("FAIL wr_done: got %b want 010", done); end
        total++; if (rsp_slverr !== 1'b0)     begin bad++; $display("FAIL wr_slverr: got %b want 0", rsp_slverr); end
        total++; if (psel !== 2'b00 || penable !== 1'b0) begin bad++; $display("FAIL wr_drop: got psel=%b pen=%b want 00/0", psel, penable); end
        req = 3'b000;
        tick();
        total++; if (done !== 3'b000)         begin bad++; $display("FAIL wr_done_pulse: got %b want 000", done); end
    endtask

    task automatic test_read_wait;
        req_addr[0]  = 32'h0000_1004;
        req_write[0] = 1'b0;
        req_strb[0]  = 4'hF;
        prdata  = 32'hCAFE_1234;
        pready  = 1'b0;
        req = 3'b001;
        tick();
        total++; if (psel !== 2'b10)   begin bad++; $display("FAIL rd_setup_psel: got %b want 10", psel); end
        total++; if (pstrb !== 4'h0)   begin bad++; $display("FAIL rd_pstrb: got %h want 0", pstrb); end
        tick();
        req = 3'b000;
        for (int c = 2; c <= 4; c++) begin
            total++; if (psel !== 2'b10 || penable !== 1'b1 || done !== 3'b000) begin
                bad++; $display("FAIL rd_wait_c%0d: got psel=%b pen=%b done=%b want 10/1/000", c, psel, penable, done);
            end
            tick();
        end
        pready = 1'b1;
        total++; if (psel !== 2'b10 || penable !== 1'b1) begin bad++; $display("FAIL rd_wait_c5: got psel=%b pen=%b want 10/1", psel, penable); end
        tick();
        total++; if (done !== 3'b001)          begin bad++; $display("FAIL rd_done: got %b want 001", done); end
        total++; if (rsp_rdata !== 32'hCAFE1234) begin bad++; $display("FAIL rd_rdata: got %h want cafe1234", rsp_rdata); end
        tick();
        total++; if (rsp_rdata !== 32'hCAFE1234 || done !== 3'b000) begin bad++; $display("FAIL rd_hold: got %h done=%b want cafe1234/000", rsp_rdata, done); end
    endtask

    task automatic test_round_robin;
        logic [31:0] addrs [3];
        addrs[0] = 32'h0000_0100;
        addrs[1] = 32'h0000_0204;
        addrs[2] = 32'h0000_0308;
        preset = 1'b1;
        @(negedge pclk);
        preset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_addr[i]  = addrs[i];
            req_write[i] = 1'b0;
        end
        prdata = 32'h5555_AAAA; pready = 1'b1; pslverr = 1'b0;
        req = 3'b111;
        for (int t = 0; t < 6; t++) begin
            int n;
            logic [2:0] exp_oh;
            n = 0;
            tick(); n++;
            while (done === 3'b000 && n < 10) begin
                tick(); n++;
            end
            exp_oh = 3'b001 << (t % 3);
            total++; if (done !== exp_oh) begin bad++; $display("FAIL rr_grant_%0d: got %b want %b", t, done, exp_oh); end
            total++; if (paddr !== addrs[t % 3]) begin bad++; $display("FAIL rr_paddr_%0d: got %h want %h", t, paddr, addrs[t % 3]); end
            total++; if (n !== 3) begin bad++; $display("FAIL rr_spacing_%0d: got %0d want 3", t, n); end
        end
        req = 3'b000;
        total++; if (rsp_rdata !== 32'h5555AAAA) begin bad++; $display("FAIL rr_rdata: got %h want 5555aaaa", rsp_rdata); end
        tick();
    endtask

    task automatic test_decerr;
        req_addr[2]  = 32'h0000_3000;
        req_write[2] = 1'b0;
        req = 3'b100;
        tick();
        total++; if (psel !== 2'b00 || penable !== 1'b0 || done !== 3'b000) begin
            bad++; $display("FAIL de_c1: got psel=%b pen=%b done=%b want 00/0/000", psel, penable, done);
        end
        tick();
        total++; if (done !== 3'b100)     begin bad++; $display("FAIL de_done: got %b want 100", done); end
        total++; if (rsp_slverr !== 1'b1) begin bad++; $display("FAIL de_slverr: got %b want 1", rsp_slverr); end
        total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL de_rdata: got %h want 0", rsp_rdata); end
        total++; if (psel !== 2'b00)      begin bad++; $display("FAIL de_psel: got %b want 00", psel); end
        req = 3'b000;
        tick();
    endtask

    task automatic test_slverr;
        req_addr[1]  = 32'h0000_1000;
        req_write[1] = 1'b1;
        req_wdata[1] = 32'h0000_0001;
        pready = 1'b1; pslverr = 1'b1;
        req = 3'b010;
        tick();
        total++; if (psel !== 2'b10)      begin bad++; $display("FAIL se_psel: got %b want 10", psel); end
        tick();
        tick();
        total++; if (done !== 3'b010)     begin bad++; $display("FAIL se_done: got %b want 010", done); end
        total++; if (rsp_slverr !== 1'b1) begin bad++; $display("FAIL se_slverr: got %b want 1", rsp_slverr); end
        total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL se_rdata: got %h want 0", rsp_rdata); end
        pslverr = 1'b0;
        req = 3'b000;
        tick();
    endtask

    task automatic test_reset_mid;
        req_addr[0]  = 32'h0000_1000;
        req_write[0] = 1'b0;
        req_addr[2]  = 32'h0000_0040;
        req_write[2] = 1'b0;
        pready = 1'b0;
        req = 3'b001;
        tick(); tick(); tick();
        total++; if (penable !== 1'b1) begin bad++; $display("FAIL rm_access: got %b want 1", penable); end
        preset = 1'b1;
        #1;
        total++; if (psel !== 2'b00 || penable !== 1'b0 || done !== 3'b000 || paddr !== 32'h0) begin
            bad++; $display("FAIL rm_async: got psel=%b pen=%b done=%b paddr=%h want all 0", psel, penable, done, paddr);
        end
        @(posedge pclk);
        @(negedge pclk);
        total++; if (done !== 3'b000) begin bad++; $display("FAIL rm_no_done: got %b want 000", done); end
        preset = 1'b0;
        pready = 1'b1;
        req = 3'b101;
        tick();
        total++; if (paddr !== 32'h1000 || psel !== 2'b10) begin bad++; $display("FAIL rm_ptr0: got paddr=%h psel=%b want 1000/10", paddr, psel); end
        tick(); tick();
        total++; if (done !== 3'b001) begin bad++; $display("FAIL rm_done0: got %b want 001", done); end
        req = 3'b100;
        tick();
        total++; if (paddr !== 32'h40 || psel !== 2'b01) begin bad++; $display("FAIL rm_req2: got paddr=%h psel=%b want 40/01", paddr, psel); end
        tick(); tick();
        total++; if (done !== 3'b100) begin bad++; $display("FAIL rm_done2: got %b want 100", done); end
        req = 3'b000;
        tick();
    endtask

`ifdef APB_ARB_TIMEOUT_EN
    task automatic test_timeout;
        int n;
        req_addr[1]  = 32'h0000_0000;
        req_write[1] = 1'b0;
        prdata = 32'h1234_5678;
        pready = 1'b0;
        req = 3'b010;
        n = 0;
        tick(); n++;
        while (done === 3'b000 && n < 40) begin
            tick(); n++;
        end
        req = 3'b000;
        total++; if (n !== 18)            begin bad++; $display("FAIL to_latency: got %0d want 18", n); end
        total++; if (done !== 3'b010)     begin bad++; $display("FAIL to_done: got %b want 010", done); end
        total++; if (rsp_slverr !== 1'b1) begin bad++; $display("FAIL to_slverr: got %b want 1", rsp_slverr); end
        total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL to_rdata: got %h want 0", rsp_rdata); end
        total++; if (psel !== 2'b00)      begin bad++; $display("FAIL to_psel: got %b want 00", psel); end
        pready = 1'b1;
        tick();
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        preset    = 1'b1;
        req       = '0;
        req_addr  = '0;
        req_write = '0;
        req_wdata = '0;
        req_strb  = '0;
        req_prot  = '0;
        pready    = 1'b1;
        prdata    = '0;
        pslverr   = 1'b0;
        test_reset();
        test_single_write();
        test_read_wait();
        test_round_robin();
        test_decerr();
        test_slverr();
        test_reset_mid();
`ifdef APB_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
